// File: rtl/glyph_pkg.sv
// Shared constants for the glyph recognizer: candidate code list, glyph geometry and FSM states.
package glyph_pkg;

  localparam int unsigned CAND_COUNT = 70;
  localparam int unsigned GLYPH_W    = 5;
  localparam int unsigned GLYPH_H    = 8;
  localparam int unsigned CAND_W     = 7;

  // Scan order matters: the first matching entry wins.
  localparam logic [7:0] CAND_LIST [CAND_COUNT] = '{
    8'd32,  8'd46,  8'd38,  8'd42,  8'd43,  8'd45,
    8'd48,  8'd49,  8'd50,  8'd51,  8'd52,  8'd53,  8'd54,  8'd55,  8'd56,  8'd57,
    8'd65,  8'd66,  8'd67,  8'd68,  8'd69,  8'd70,  8'd71,  8'd72,  8'd73,  8'd74,
    8'd75,  8'd76,  8'd77,  8'd78,  8'd79,  8'd80,  8'd81,  8'd82,  8'd83,  8'd84,
    8'd85,  8'd86,  8'd87,  8'd88,  8'd89,  8'd90,
    8'd97,  8'd98,  8'd99,  8'd100, 8'd101, 8'd102, 8'd103, 8'd104, 8'd105, 8'd106,
    8'd107, 8'd108, 8'd109, 8'd110, 8'd111, 8'd112, 8'd113, 8'd114, 8'd115, 8'd116,
    8'd117, 8'd118, 8'd119, 8'd120, 8'd121, 8'd122,
    8'd124, 8'd164
  };

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_t;

endpackage

// File: rtl/glyph_scan_cnt.sv
// Pixel (x, y) and candidate index counters for the glyph scan, with end-of-range flags.
module glyph_scan_cnt
  import glyph_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              step_i,
  input  logic              next_cand_i,
  output logic [2:0]        x_o,
  output logic [2:0]        y_o,
  output logic [CAND_W-1:0] cand_idx_o,
  output logic              last_pixel_o,
  output logic              last_cand_o
);

  logic [2:0]        x_q, x_d, y_q, y_d;
  logic [CAND_W-1:0] cand_q, cand_d;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    cand_d = cand_q;
    if (clear_i) begin
      x_d    = '0;
      y_d    = '0;
      cand_d = '0;
    end else if (next_cand_i) begin
      x_d    = '0;
      y_d    = '0;
      cand_d = cand_q + 1'b1;
    end else if (step_i) begin
      // Column wraps at GLYPH_W, not at the natural 3-bit boundary.
      if (x_q == 3'(GLYPH_W - 1)) begin
        x_d = '0;
        y_d = (y_q == 3'(GLYPH_H - 1)) ? 3'd0 : y_q + 3'd1;
      end else begin
        x_d = x_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      cand_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      cand_q <= cand_d;
    end
  end

  assign x_o          = x_q;
  assign y_o          = y_q;
  assign cand_idx_o   = cand_q;
  assign last_pixel_o = (x_q == 3'(GLYPH_W - 1)) && (y_q == 3'(GLYPH_H - 1));
  assign last_cand_o  = (cand_q == CAND_W'(CAND_COUNT - 1));

endmodule

// File: rtl/glyph_recognizer.sv
// Finds the character code whose ROM glyph equals a captured 5x8 bitmap by scanning candidates
// pixel by pixel through the external combinational glyph ROM.
module glyph_recognizer
  import glyph_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [39:0] in_bitmap,
  output logic [7:0]  rom_select,
  output logic [2:0]  rom_coor_x,
  output logic [2:0]  rom_coor_y,
  input  logic        rom_pixel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_code,
  output logic        out_hit,
  output logic        busy
);

  state_t            state_q;
  logic [39:0]       bitmap_q;
  logic              mismatch_q;
  logic [2:0]        x, y;
  logic [CAND_W-1:0] cand_idx;
  logic              last_pixel, last_cand;
  logic              cnt_clear, cnt_step, cnt_next;
  logic [5:0]        bit_idx;
  logic              pix_bad, cand_fail, cand_hit, accept;

  glyph_scan_cnt u_scan_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (cnt_clear),
    .step_i       (cnt_step),
    .next_cand_i  (cnt_next),
    .x_o          (x),
    .y_o          (y),
    .cand_idx_o   (cand_idx),
    .last_pixel_o (last_pixel),
    .last_cand_o  (last_cand)
  );

  assign rom_select = CAND_LIST[cand_idx];
  assign rom_coor_x = x;
  assign rom_coor_y = y;

  assign bit_idx = {3'b000, y} * 6'd5 + {3'b000, x};
  assign pix_bad = rom_pixel != bitmap_q[bit_idx];
  assign accept  = (state_q == StIdle) && in_valid && in_ready;

  always_comb begin
    cand_fail = 1'b0;
    cand_hit  = 1'b0;
    cnt_clear = accept;
    cnt_step  = 1'b0;
    cnt_next  = 1'b0;
    if (EARLY_EXIT) begin
      cand_fail = pix_bad;
    end else begin
      cand_fail = last_pixel && (mismatch_q || pix_bad);
    end
    cand_hit = last_pixel && !pix_bad && !mismatch_q;
    if (state_q == StScan) begin
      cnt_step = !cand_fail && !cand_hit;
      cnt_next = cand_fail && !last_cand;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bitmap_q   <= '0;
      mismatch_q <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_code   <= '0;
      out_hit    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            bitmap_q   <= in_bitmap;
            mismatch_q <= 1'b0;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
            state_q    <= StScan;
          end
        end
        StScan: begin
          if (cand_hit) begin
            out_hit  <= 1'b1;
            out_code <= CAND_LIST[cand_idx];
            busy     <= 1'b0;
            state_q  <= StDone;
          end else if (cand_fail) begin
            mismatch_q <= 1'b0;
            if (last_cand) begin
              out_hit  <= 1'b0;
              out_code <= '0;
              busy     <= 1'b0;
              state_q  <= StDone;
            end
          end else if (pix_bad) begin
            // Only reachable without early exit: remember the miss until the candidate ends.
            mismatch_q <= 1'b1;
          end
        end
        StDone: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
